rf_writeback: RTL and testbench
===============================

# rf_writeback

Write-side initiator for the integer register file. Collects completed results from the ALU and the load/store unit through valid/ready handshakes and buffers them in a small in-order queue. Drains exactly one entry per cycle into the register file's single write port. Offers a forwarding lookup so the decode stage can read values still pending in the queue.

## Interface
- WIDTH, 32, data width (XLEN)
- ADDR_W, 5, register address width
- DEPTH, 4, queue entries (power of two, ≥2)

- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  WIDTH  ALU result
- lsu_valid  in  1  load result present
- lsu_ready  out  1  load result accepted when high with lsu_valid
- lsu_rd  in  ADDR_W  load destination register
- lsu_data  in  WIDTH  load data
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  WIDTH  register-file write data
- fwd_addr  in  ADDR_W  forwarding lookup address
- fwd_hit  out  1  a pending entry targets fwd_addr
- fwd_data  out  WIDTH  data of youngest matching pending entry
- empty  out  1  queue empty
- full  out  1  queue full

## Operation
- Circular queue with head/tail pointers of log2(DEPTH) bits (wrap modulo DEPTH) and a count of log2(DEPTH)+1 bits.
- Free slots: F = DEPTH − count, using the registered count only. A same-cycle dequeue gives no credit.
- alu_ready = (F ≥ 1).
- lsu_ready = (F ≥ 2) or (F ≥ 1 and not (alu_valid and alu_rd ≠ 0)). ALU has priority.
- A transfer with rd = 0 completes the handshake (ready as above) but is discarded. It is never enqueued and never written.
- Both sources enqueued in the same cycle: ALU entry goes to tail, LSU entry to tail+1. The ALU entry is older.
- Drain: when count ≠ 0, head is presented on the write port. Head pops at the end of every cycle. There is no backpressure from the register file.
- rf_we = (count ≠ 0). rf_waddr/rf_wdata = head entry. Both are 0 when empty.
- Forwarding: combinational search of all valid entries, including the head being written this cycle. The youngest match wins. fwd_addr = 0 gives fwd_hit = 0. On a miss, fwd_data = 0.
- count_next = count + enq_count − deq (enq_count ∈ {0,1,2}). count never exceeds DEPTH.
- empty = (count = 0). full = (count = DEPTH).

## Timing
- Reset: head, tail and count go to 0; rf_we = 0, rf_waddr = 0, rf_wdata = 0; fwd_hit = 0; empty = 1, full = 0. alu_ready = 1 and lsu_ready = 1 in the first cycle after reset.
- Reset mid-operation discards all pending entries with no write issued. Handshakes in the reset cycle are not accepted.
- Latency: result accepted in cycle N appears on rf_we in cycle N+1 at the earliest. Throughput is 1 write/cycle.
- Ready is combinational from registered state and alu_valid/alu_rd. No path from lsu_valid to any ready.
- Full queue with a simultaneous drain: ready stays low that cycle. The slot is usable in the next cycle.
- Entry storage has no reset. Validity is derived from the pointers and count.

## Structure
- Shared package rf_pkg holds XLEN, REG_ADDR_W and typedef wb_entry_t {rd, data}. This package is shared with the register file and decode stage.
- Sub-module rf_wb_fifo: the storage array with pointers, a two-port enqueue, a single dequeue, and an exported entry array plus valid mask for the forwarding search.
- The top level contains arbitration, rd = 0 filtering and the forwarding priority mux.

## Test plan
- Single ALU write rd=5, data=0xDEADBEEF at cycle 1 -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at cycle 2; empty=1 at cycle 3.
- ALU rd=3/0x11 and LSU rd=4/0x22 in the same cycle on an empty queue -> writes to r3 then r4 on consecutive cycles.
- ALU rd=0 data=0xFFFF -> alu_ready=1, no rf_we, count stays 0. LSU rd=0 likewise.
- Fill to DEPTH=4 with rd=1..4 -> full=1, both readies 0. Simultaneous offers refused for one cycle, accepted the next. Order holds across pointer wrap.
- Pending r7=0xA then r7=0xB in the queue, fwd_addr=7 -> fwd_hit=1, fwd_data=0xB. fwd_addr=0 -> fwd_hit=0.
- Queue with 3 entries, reset asserted for one cycle -> rf_we=0 immediately after the reset edge, empty=1, no stale write afterwards.

Source files
------------

// File: rtl/rf_pkg.sv
// Register-file types shared by write-back, the register file and decode.
package rf_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// In-order write-back queue: two-port enqueue (port 0 older), one dequeue, full entry view.
// Latency: an entry written this cycle is visible at the head next cycle at the earliest.
// Backpressure: none internally; the caller must never enqueue beyond the free slots.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq0_vld,
  input  wb_entry_t                enq0_dat,
  input  logic                     enq1_vld,
  input  wb_entry_t                enq1_dat,
  input  logic                     deq_vld,
  output wb_entry_t                head_dat,
  output logic [$clog2(DEPTH)-1:0] head_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t                ent_dat [DEPTH],
  output logic [DEPTH-1:0]         ent_vld
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] enq1_ptr;
  logic             deq;

  // Port 1 lands behind port 0 only when port 0 is also writing.
  assign enq1_ptr = tail_ptr + PTR_W'(enq0_vld);
  assign deq      = deq_vld && (count != '0);

  always_ff @(posedge clk) begin
    if (enq0_vld) mem[tail_ptr] <= enq0_dat;
    if (enq1_vld) mem[enq1_ptr] <= enq1_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      head_ptr <= head_ptr + PTR_W'(deq);
      tail_ptr <= tail_ptr + PTR_W'(enq0_vld) + PTR_W'(enq1_vld);
      count    <= count + CNT_W'(enq0_vld) + CNT_W'(enq1_vld) - CNT_W'(deq);
    end
  end

  assign head_dat = mem[head_ptr];
  assign ent_dat  = mem;

  always_comb begin
    ent_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i] = ({1'b0, PTR_W'(i) - head_ptr} < count);
    end
  end
endmodule

// File: rtl/rf_writeback.sv
// Register-file write-back initiator: arbitrates ALU/LSU results into a queue drained one per cycle.
// Latency: a result accepted in cycle N is written in cycle N+1 at the earliest.
// Backpressure: readies come from registered free slots only; ALU wins the last slot.
module rf_writeback
  import rf_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [WIDTH-1:0]  alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [WIDTH-1:0]  lsu_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]  rf_wdata,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [WIDTH-1:0]  fwd_data,
  output logic              empty,
  output logic              full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free_slots;
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] fwd_idx;
  wb_entry_t        head_dat;
  wb_entry_t        alu_ent;
  wb_entry_t        lsu_ent;
  wb_entry_t        ent_dat [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic             alu_live;
  logic             alu_enq;
  logic             lsu_enq;

  // Credit is taken from the registered count; this cycle's drain frees nothing yet.
  assign free_slots = DEPTH_C - count;
  assign alu_live   = alu_valid && (alu_rd != '0);
  assign alu_ready  = !reset && (free_slots >= CNT_W'(1));
  assign lsu_ready  = !reset && ((free_slots >= CNT_W'(2)) ||
                                 ((free_slots >= CNT_W'(1)) && !alu_live));

  // rd = 0 handshakes complete normally but never occupy a slot.
  assign alu_enq = alu_live && alu_ready;
  assign lsu_enq = lsu_valid && lsu_ready && (lsu_rd != '0);

  assign alu_ent.rd   = alu_rd;
  assign alu_ent.data = alu_data;
  assign lsu_ent.rd   = lsu_rd;
  assign lsu_ent.data = lsu_data;

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq0_vld (alu_enq),
    .enq0_dat (alu_ent),
    .enq1_vld (lsu_enq),
    .enq1_dat (lsu_ent),
    .deq_vld  (rf_we),
    .head_dat (head_dat),
    .head_ptr (head_ptr),
    .count    (count),
    .ent_dat  (ent_dat),
    .ent_vld  (ent_vld)
  );

  assign rf_we    = (count != '0);
  assign rf_waddr = rf_we ? head_dat.rd : '0;
  assign rf_wdata = rf_we ? head_dat.data : '0;
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_ptr + PTR_W'(k);
      if (ent_vld[fwd_idx] && (ent_dat[fwd_idx].rd == fwd_addr) && (fwd_addr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_dat[fwd_idx].data;
      end
    end
  end
endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: a DEPTH=4 and a DEPTH=2 instance share stimulus, each against its own queue model.
module tb_rf_writeback;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_rd, lsu_rd, fwd_addr;
  logic [31:0] alu_data, lsu_data;

  logic        alu_ready_o [2];
  logic        lsu_ready_o [2];
  logic        rf_we_o     [2];
  logic        fwd_hit_o   [2];
  logic        empty_o     [2];
  logic        full_o      [2];
  logic [4:0]  rf_waddr_o  [2];
  logic [31:0] rf_wdata_o  [2];
  logic [31:0] fwd_data_o  [2];

  rf_writeback #(.WIDTH(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready_o[0]), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready_o[0]), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we_o[0]), .rf_waddr(rf_waddr_o[0]), .rf_wdata(rf_wdata_o[0]),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit_o[0]), .fwd_data(fwd_data_o[0]),
    .empty(empty_o[0]), .full(full_o[0])
  );

  rf_writeback #(.WIDTH(32), .ADDR_W(5), .DEPTH(2)) dut_d2 (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready_o[1]), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready_o[1]), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we_o[1]), .rf_waddr(rf_waddr_o[1]), .rf_wdata(rf_wdata_o[1]),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit_o[1]), .fwd_data(fwd_data_o[1]),
    .empty(empty_o[1]), .full(full_o[1])
  );

  int checks   = 0;
  int failures = 0;
  bit en       = 1'b0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Model: pending writes as a plain list, oldest at index 0.
  ent_t mq  [2][8];
  int   msz [2] = '{0, 0};
  int   dep [2] = '{4, 2};
  bit   acc_a, acc_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_alu_rdy(input int i);
    return (dep[i] - msz[i]) >= 1;
  endfunction

  function automatic bit m_lsu_rdy(input int i);
    int f;
    f = dep[i] - msz[i];
    return (f >= 2) || ((f >= 1) && !(alu_valid && (alu_rd != 5'd0)));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      acc_a = !reset && alu_valid && m_alu_rdy(i) && (alu_rd != 5'd0);
      acc_l = !reset && lsu_valid && m_lsu_rdy(i) && (lsu_rd != 5'd0);
      if (reset) begin
        msz[i] = 0;
      end else begin
        if (msz[i] > 0) begin
          for (int j = 0; j < 7; j++) mq[i][j] = mq[i][j+1];
          msz[i]--;
        end
        if (acc_a) begin mq[i][msz[i]] = {alu_rd, alu_data}; msz[i]++; end
        if (acc_l) begin mq[i][msz[i]] = {lsu_rd, lsu_data}; msz[i]++; end
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      for (int i = 0; i < 2; i++) begin
        bit          ew, eh;
        logic [4:0]  ea;
        logic [31:0] ed, efd;
        ew  = msz[i] > 0;
        ea  = ew ? mq[i][0].rd : 5'd0;
        ed  = ew ? mq[i][0].data : 32'd0;
        eh  = 1'b0;
        efd = 32'd0;
        for (int j = 0; j < msz[i]; j++) begin
          if ((fwd_addr != 5'd0) && (mq[i][j].rd == fwd_addr)) begin
            eh  = 1'b1;
            efd = mq[i][j].data;
          end
        end
        chk($sformatf("d%0d.rf_we", dep[i]),    rf_we_o[i],    ew);
        chk($sformatf("d%0d.rf_waddr", dep[i]), rf_waddr_o[i], ea);
        chk($sformatf("d%0d.rf_wdata", dep[i]), rf_wdata_o[i], ed);
        chk($sformatf("d%0d.empty", dep[i]),    empty_o[i],    msz[i] == 0);
        chk($sformatf("d%0d.full", dep[i]),     full_o[i],     msz[i] == dep[i]);
        chk($sformatf("d%0d.fwd_hit", dep[i]),  fwd_hit_o[i],  eh);
        chk($sformatf("d%0d.fwd_data", dep[i]), fwd_data_o[i], efd);
        if (!reset) begin
          chk($sformatf("d%0d.alu_ready", dep[i]), alu_ready_o[i], m_alu_rdy(i));
          chk($sformatf("d%0d.lsu_ready", dep[i]), lsu_ready_o[i], m_lsu_rdy(i));
        end
      end
    end
  end

  task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ld);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    fwd_addr = 5'd0;
    idle();
    tick();
    en = 1'b1;
    tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst.rf_we", rf_we_o[0], 0);
    chk("rst.rf_waddr", rf_waddr_o[0], 0);
    chk("rst.rf_wdata", rf_wdata_o[0], 0);
    chk("rst.empty", empty_o[0], 1);
    chk("rst.full", full_o[0], 0);
    chk("rst.alu_ready", alu_ready_o[0], 1);
    chk("rst.lsu_ready", lsu_ready_o[0], 1);
    chk("rst.fwd_hit", fwd_hit_o[0], 0);
    tick();

    // Single ALU write
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("t1.alu_ready", alu_ready_o[0], 1);
    tick();
    idle();
    fwd_addr = 5'd5;
    @(negedge clk);
    chk("t1.rf_we", rf_we_o[0], 1);
    chk("t1.rf_waddr", rf_waddr_o[0], 5);
    chk("t1.rf_wdata", rf_wdata_o[0], 32'hDEADBEEF);
    chk("t1.fwd_hit_head", fwd_hit_o[0], 1);
    chk("t1.fwd_data_head", fwd_data_o[0], 32'hDEADBEEF);
    tick();
    fwd_addr = 5'd0;
    @(negedge clk);
    chk("t1.empty", empty_o[0], 1);
    chk("t1.rf_we_after", rf_we_o[0], 0);
    tick();

    // Dual enqueue: ALU older than LSU
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    @(negedge clk);
    chk("t2.lsu_ready", lsu_ready_o[0], 1);
    tick();
    idle();
    fwd_addr = 5'd4;
    @(negedge clk);
    chk("t2.waddr0", rf_waddr_o[0], 3);
    chk("t2.wdata0", rf_wdata_o[0], 32'h11);
    chk("t2.fwd_data", fwd_data_o[0], 32'h22);
    tick();
    @(negedge clk);
    chk("t2.waddr1", rf_waddr_o[0], 4);
    chk("t2.wdata1", rf_wdata_o[0], 32'h22);
    tick();
    fwd_addr = 5'd0;
    @(negedge clk);
    chk("t2.empty", empty_o[0], 1);
    tick();

    // rd = 0 is accepted and dropped
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("t3.alu_ready", alu_ready_o[0], 1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
    @(negedge clk);
    chk("t3.alu_rd0_no_we", rf_we_o[0], 0);
    chk("t3.lsu_ready", lsu_ready_o[0], 1);
    tick();
    idle();
    @(negedge clk);
    chk("t3.lsu_rd0_no_we", rf_we_o[0], 0);
    chk("t3.empty", empty_o[0], 1);
    tick();

    // Full queue on the DEPTH=2 instance
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    tick();
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    @(negedge clk);
    chk("t4.full", full_o[1], 1);
    chk("t4.alu_ready_full", alu_ready_o[1], 0);
    chk("t4.lsu_ready_full", lsu_ready_o[1], 0);
    chk("t4.waddr_a", rf_waddr_o[1], 1);
    tick();
    @(negedge clk);
    chk("t4.not_full", full_o[1], 0);
    chk("t4.alu_ready_next", alu_ready_o[1], 1);
    chk("t4.lsu_ready_prio", lsu_ready_o[1], 0);
    chk("t4.waddr_b", rf_waddr_o[1], 2);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h4);
    @(negedge clk);
    chk("t4.waddr_c", rf_waddr_o[1], 3);
    chk("t4.lsu_ready_alone", lsu_ready_o[1], 1);
    tick();
    idle();
    @(negedge clk);
    chk("t4.waddr_d", rf_waddr_o[1], 4);
    repeat (5) tick();

    // Sustained traffic across pointer wrap, checked by the model
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i % 5 == 0) ? 5'd0 : 5'(i + 1), 32'h100 + 32'(i),
            1'b1, 5'(i + 17), 32'h200 + 32'(i));
      fwd_addr = 5'(i + 1);
      tick();
    end
    idle();
    fwd_addr = 5'd0;
    repeat (6) tick();

    // Forwarding picks the youngest match
    drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    tick();
    idle();
    fwd_addr = 5'd7;
    @(negedge clk);
    chk("t5.fwd_hit", fwd_hit_o[0], 1);
    chk("t5.fwd_data", fwd_data_o[0], 32'hB);
    chk("t5.fwd_data_d2", fwd_data_o[1], 32'hB);
    tick();
    fwd_addr = 5'd0;
    @(negedge clk);
    chk("t5.fwd_addr0", fwd_hit_o[0], 0);
    tick();
    fwd_addr = 5'd7;
    repeat (2) tick();
    fwd_addr = 5'd0;

    // Reset with three pending entries
    drive(1'b1, 5'd8, 32'h80, 1'b1, 5'd9, 32'h90);
    tick();
    drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0);
    tick();
    drive(1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("t6.pending_we", rf_we_o[0], 1);
    chk("t6.pending_addr", rf_waddr_o[0], 9);
    tick();
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("t6.rf_we", rf_we_o[0], 0);
    chk("t6.empty", empty_o[0], 1);
    chk("t6.rf_we_d2", rf_we_o[1], 0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
